// File: rtl/tc_rom_arbiter.sv
// tc_rom_arbiter: round-robin arbiter sharing the single registered read port
// of the TC file ROM between two requesters (e.g. fetch and load).
// One ROM transaction is in flight at a time; each requester has a
// valid/ready request channel and a valid/ready response channel.
// Optional build macro: ROM_BOUNDS_CHECK_EN. When defined, a request whose
// 8-byte window reaches past FILE_BYTES is answered with err=1 and data=0
// without touching the ROM. The all-ones size query is exempt.
module tc_rom_arbiter #(
  parameter int ROM_LATENCY = 1,
  parameter int FILE_BYTES  = 302
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        req0_valid,
  input  logic [63:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [63:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        rsp0_ready,
  // requester 1
  input  logic        req1_valid,
  input  logic [63:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [63:0] rsp1_data,
  output logic        rsp1_err,
  input  logic        rsp1_ready,
  // ROM port
  output logic        rom_en,
  output logic [63:0] rom_address,
  input  logic [63:0] rom_out,
  output logic        busy
);

  // Elaboration-time parameter sanity: the wait counter is 4 bits wide.
  if (ROM_LATENCY < 1 || ROM_LATENCY > 15) begin : g_bad_latency
    $error("tc_rom_arbiter: ROM_LATENCY must be in 1..15");
  end
  if (FILE_BYTES < 1) begin : g_bad_file_bytes
    $error("tc_rom_arbiter: FILE_BYTES must be positive");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        rr_ptr;     // 0: req0 wins a tie, 1: req1 wins a tie
  logic        grant_q;    // id of the requester being served
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic [3:0]  cnt;

  logic        any_req;
  logic        win_id;
  logic [63:0] win_addr;
  logic        oob;        // granted request is out of bounds

  // Pick the winner among the currently valid requesters.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    win_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    win_addr = win_id ? req1_addr : req0_addr;
  end

`ifdef ROM_BOUNDS_CHECK_EN
  logic [64:0] end_addr;
  logic        err_q;

  // Last byte of the 8-byte window, computed one bit wider so it cannot wrap.
  always_comb begin
    end_addr = {1'b0, win_addr} + 65'd7;
    oob      = !(&win_addr) && (end_addr >= 65'(FILE_BYTES));
  end

  // Error flag latched at grant and held through the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && any_req) begin
      err_q <= oob;
    end
  end

  assign rsp0_err = rsp0_valid & err_q;
  assign rsp1_err = rsp1_valid & err_q;
`else
  assign oob      = 1'b0;
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  // State register plus the transaction bookkeeping registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      grant_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            addr_q  <= win_addr;
            grant_q <= win_id;
            rr_ptr  <= ~win_id;
            // Cleared here so a bounds-rejected request answers with zero.
            data_q  <= '0;
          end
        end
        ISSUE: cnt <= 4'(ROM_LATENCY - 1);
        WAIT: begin
          if (cnt == 4'd0) begin
            data_q <= rom_out;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and all handshake / ROM-port outputs.
  // NOTE: every output gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rom_en      = 1'b0;
    rom_address = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~win_id;
          req1_ready = win_id;
          state_nxt  = oob ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        rom_en      = 1'b1;
        rom_address = addr_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        rom_en      = 1'b1;
        rom_address = addr_q;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp0_data = rsp0_valid ? data_q : '0;
  assign rsp1_data = rsp1_valid ? data_q : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tc_rom_arbiter.sv
// Testbench for tc_rom_arbiter: models the TC file ROM as a byte image and
// checks arbitration order, latency, backpressure, size query, reset abort,
// the optional bounds check, and a randomized run against a reference model.
module tb_tc_rom_arbiter;
  localparam int FILE_BYTES = 302;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_err, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_err, rsp1_ready;
  logic [63:0] req0_addr, req1_addr, rsp0_data, rsp1_data;
  logic        rom_en, busy;
  logic [63:0] rom_address;
  logic [63:0] rom_out = '0;

  logic [7:0]  image [FILE_BYTES];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rom_en_cycles = 0;

  always #5 clk = ~clk;

  tc_rom_arbiter #(.ROM_LATENCY(1), .FILE_BYTES(FILE_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rsp1_ready(rsp1_ready),
    .rom_en(rom_en), .rom_address(rom_address), .rom_out(rom_out), .busy(busy)
  );

  // Expected 8-byte little-endian read of the file image; bytes past the
  // end read as zero, the all-ones address returns the file size.
  function automatic logic [63:0] rom_word(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    if (&a) return 64'(FILE_BYTES);
    if (a < 64'(FILE_BYTES)) begin
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = int'(a[15:0]) + i;
        if (idx < FILE_BYTES) w[8*i +: 8] = image[idx];
      end
    end
    return w;
  endfunction

  // Registered ROM with one cycle of latency, plus an enable-cycle counter.
  always @(posedge clk) begin
    if (rom_en) rom_out <= rom_word(rom_address);
    if (rom_en) rom_en_cycles <= rom_en_cycles + 1;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b1;
    req1_valid = 1'b0; req1_addr = '0; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) until the response channel of requester id is valid.
  task automatic wait_rsp(input bit id, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (id ? rsp1_valid : rsp0_valid) begin
        got = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_tests++;
    if ({busy, rom_en, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {busy, rom_en, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready});
    end
    n_tests++;
    if ({rom_address, rsp0_data, rsp1_data} !== 192'b0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h d0=%h d1=%h exp=0", rom_address, rsp0_data, rsp1_data);
    end
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_addr = 64'h0; rsp0_ready = 1'b1;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      n_fail++; $display("FAIL single_accept got=%b exp=100", {req0_ready, req1_ready, busy});
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (rom_en !== 1'b1 || rom_address !== 64'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_issue got en=%b addr=%h busy=%b exp en=1 addr=0 busy=1", rom_en, rom_address, busy);
    end
    tick();
    n_tests++;
    if (rom_en !== 1'b1 || rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_wait got en=%b v0=%b exp en=1 v0=0", rom_en, rsp0_valid);
    end
    tick();
    n_tests++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 64'h0807060504030201 || rsp1_valid !== 1'b0 || rom_en !== 1'b0) begin
      n_fail++; $display("FAIL single_resp got v0=%b d=%h v1=%b en=%b exp v0=1 d=0807060504030201 v1=0 en=0", rsp0_valid, rsp0_data, rsp1_valid, rom_en);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_done got busy=%b v0=%b exp 0 0", busy, rsp0_valid);
    end
  endtask

  task automatic test_alternate;
    bit exp_id, got;
    do_reset();
    req0_valid = 1'b1; req0_addr = 64'h10;
    req1_valid = 1'b1; req1_addr = 64'h20;
    exp_id = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_grant%0d got r1r0=%b exp grant=%0d", k, {req1_ready, req0_ready}, exp_id);
      end
      tick();
      wait_rsp(exp_id, got);
      n_tests++;
      if (!got || (exp_id ? rsp1_data : rsp0_data) !== rom_word(exp_id ? 64'h20 : 64'h10)
          || (exp_id ? rsp0_valid : rsp1_valid) !== 1'b0) begin
        n_fail++; $display("FAIL alt_rsp%0d got valid=%b data=%h exp data=%h", k, got, exp_id ? rsp1_data : rsp0_data, rom_word(exp_id ? 64'h20 : 64'h10));
      end
      tick();
      exp_id = ~exp_id;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure;
    bit got;
    logic [63:0] exp_d;
    req1_valid = 1'b1; req1_addr = 64'h28; rsp1_ready = 1'b0;
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept got=%b exp=1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_rsp(1'b1, got);
    req0_valid = 1'b1; req0_addr = 64'h30;
    exp_d = rom_word(64'h28);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (!got || rsp1_valid !== 1'b1 || rsp1_data !== exp_d || req0_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v1=%b d1=%h r0=%b exp v1=1 d1=%h r0=0", i, rsp1_valid, rsp1_data, req0_ready, exp_d);
      end
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_grant got r0=%b busy=%b exp r0=1 busy=0", req0_ready, busy);
    end
    tick();
    req0_valid = 1'b0;
    wait_rsp(1'b0, got);
    n_tests++;
    if (!got || rsp0_data !== rom_word(64'h30)) begin
      n_fail++; $display("FAIL bp_req0_data got=%h exp=%h", rsp0_data, rom_word(64'h30));
    end
    tick();
  endtask

  task automatic test_all_ones;
    bit got;
    req0_valid = 1'b1; req0_addr = '1;
    tick();
    req0_valid = 1'b0;
    wait_rsp(1'b0, got);
    n_tests++;
    if (!got || rsp0_data !== 64'd302 || rsp0_err !== 1'b0) begin
      n_fail++; $display("FAIL all_ones got valid=%b data=%0d err=%b exp data=302 err=0", got, rsp0_data, rsp0_err);
    end
    tick();
  endtask

`ifdef ROM_BOUNDS_CHECK_EN
  task automatic test_bounds;
    bit got;
    int c0;
    c0 = rom_en_cycles;
    req0_valid = 1'b1; req0_addr = 64'd300;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL oob_accept got=%b exp=1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_data !== 64'h0 || rom_en !== 1'b0) begin
      n_fail++; $display("FAIL oob_300 got v=%b err=%b d=%h en=%b exp v=1 err=1 d=0 en=0", rsp0_valid, rsp0_err, rsp0_data, rom_en);
    end
    tick();
    n_tests++;
    if (rom_en_cycles !== c0) begin
      n_fail++; $display("FAIL oob_rom_en got=%0d exp=%0d", rom_en_cycles, c0);
    end
    req1_valid = 1'b1; req1_addr = 64'hFFFF_FFFF_FFFF_FFF9;
    tick();
    req1_valid = 1'b0;
    wait_rsp(1'b1, got);
    n_tests++;
    if (!got || rsp1_err !== 1'b1 || rsp1_data !== 64'h0) begin
      n_fail++; $display("FAIL oob_nowrap got err=%b d=%h exp err=1 d=0", rsp1_err, rsp1_data);
    end
    tick();
    req0_valid = 1'b1; req0_addr = 64'd294;
    tick();
    req0_valid = 1'b0;
    wait_rsp(1'b0, got);
    n_tests++;
    if (!got || rsp0_err !== 1'b0 || rsp0_data !== rom_word(64'd294)) begin
      n_fail++; $display("FAIL inb_294 got err=%b d=%h exp err=0 d=%h", rsp0_err, rsp0_data, rom_word(64'd294));
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    bit got;
    req1_valid = 1'b1; req1_addr = 64'h40;
    tick();
    req1_valid = 1'b0;
    tick();
    n_tests++;
    if (rom_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_wait got en=%b busy=%b exp 1 1", rom_en, busy);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({busy, rsp0_valid, rsp1_valid, rom_en} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_abort got=%b exp=0000", {busy, rsp0_valid, rsp1_valid, rom_en});
    end
    rst = 1'b0;
    tick();
    req1_valid = 1'b1; req1_addr = 64'h48;
    #1;
    n_tests++;
    if (rsp1_valid !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fresh got v1=%b r1=%b exp v1=0 r1=1", rsp1_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_rsp(1'b1, got);
    n_tests++;
    if (!got || rsp1_data !== rom_word(64'h48)) begin
      n_fail++; $display("FAIL rstmid_data got=%h exp=%h", rsp1_data, rom_word(64'h48));
    end
    tick();
  endtask

  // Randomized traffic; the model applies the round-robin rule directly.
  task automatic test_random;
    bit v0, v1, win, ptr, got;
    logic [63:0] a0, a1, exp_d;
    int stall;
    do_reset();
    ptr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      v0 = 1'($urandom % 2); v1 = 1'($urandom % 2);
      a0 = ($urandom % 8 == 0) ? '1 : 64'($urandom_range(0, 294));
      a1 = ($urandom % 8 == 0) ? '1 : 64'($urandom_range(0, 294));
      req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      if (!v0 && !v1) begin
        n_tests++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
          n_fail++; $display("FAIL rnd%0d_idle got=%b exp=000", t, {req0_ready, req1_ready, busy});
        end
        tick();
        continue;
      end
      win = (v0 && v1) ? ptr : v1;
      exp_d = rom_word(win ? a1 : a0);
      n_tests++;
      if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rnd%0d_grant got r1r0=%b exp grant=%0d", t, {req1_ready, req0_ready}, win);
      end
      tick();
      ptr = ~win;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(win, got);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
        #1;
        n_tests++;
        if (!got || (win ? rsp1_valid : rsp0_valid) !== 1'b1 || (win ? rsp1_data : rsp0_data) !== exp_d
            || (win ? rsp0_valid : rsp1_valid) !== 1'b0 || (win ? rsp1_err : rsp0_err) !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_rsp got valid=%b data=%h exp id=%0d data=%h", t, got, win ? rsp1_data : rsp0_data, win, exp_d);
        end
        tick();
      end
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_release got busy=%b exp=0", t, busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < FILE_BYTES; i++) image[i] = 8'(i + 1);
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_all_ones();
`ifdef ROM_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
